// File: rtl/pdm_mem_writer.sv
// Buffers completed PDM words in a small FIFO and writes them sequentially into capture memory.
// Optional popcount density accumulator is built only when PDM_DENSITY_EN is defined.
module pdm_mem_writer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int DEPTH      = 49152,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              ahb_clk,
    input  logic              rst,
    input  logic [1:0]        ctrl,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              bsy,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W:0]   wr_count,
    output logic [31:0]       density
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]    FIFO_CAP  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic [ADDR_W:0]   acc_cnt_q, acc_cnt_d;
    logic              ovf_q, ovf_d;

    logic clr, start, flush, fifo_empty, fifo_full, acc_full;
    logic take, push, drop, pop, acc_last;

    assign clr        = ctrl[1];
    assign start      = ctrl[0];
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FIFO_CAP);
    assign acc_full   = (acc_cnt_q == DEPTH_C);
    // Entering RUN from IDLE starts a fresh capture, so it shares the clear path.
    assign flush      = clr || (state_q == S_IDLE && start);
    assign pop        = mem_we && mem_ack;
    assign take       = (state_q == S_RUN) && in_valid && !acc_full;
    assign push       = take && (!fifo_full || pop);
    assign drop       = take && fifo_full && !pop;
    assign acc_last   = push && ((acc_cnt_q + (ADDR_W+1)'(1)) == DEPTH_C);

    always_ff @(posedge ahb_clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_RUN;
                S_RUN:   if (!start || acc_full || acc_last) state_d = S_DRAIN;
                S_DRAIN: if (fifo_empty) state_d = S_DONE;
                S_DONE:  if (!start) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bsy       = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            S_RUN, S_DRAIN: begin
                bsy    = 1'b1;
                mem_we = !fifo_empty;
                if (!fifo_empty) mem_wdata = fifo_mem_q[rd_ptr_q];
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_count_d = wr_count_q;
        acc_cnt_d  = acc_cnt_q;
        ovf_d      = ovf_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            addr_d     = '0;
            wr_count_d = '0;
            acc_cnt_d  = '0;
            ovf_d      = 1'b0;
        end else begin
            if (push) begin
                fifo_mem_d[wr_ptr_q] = in_data;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                acc_cnt_d = acc_cnt_q + (ADDR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                wr_count_d = wr_count_q + (ADDR_W+1)'(1);
                // Hold on the last address so it never points past the capture region.
                if (addr_q != ADDR_LAST) addr_d = addr_q + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge ahb_clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wr_count_q <= '0;
            acc_cnt_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_count_q <= wr_count_d;
            acc_cnt_q  <= acc_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge ahb_clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign mem_addr = addr_q;
    assign wr_count = wr_count_q;
    assign ovf      = ovf_q;

`ifdef PDM_DENSITY_EN
    logic [31:0] density_q, density_d;

    function automatic logic [31:0] popcnt(input logic [DATA_W-1:0] w);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < DATA_W; i++) s = s + {31'b0, w[i]};
        return s;
    endfunction

    always_comb begin
        density_d = density_q;
        if (flush)     density_d = '0;
        else if (push) density_d = density_q + popcnt(in_data);
    end

    always_ff @(posedge ahb_clk) begin
        if (rst) density_q <= '0;
        else     density_q <= density_d;
    end

    assign density = density_q;
`else
    assign density = '0;
`endif

endmodule

// File: tb/tb_pdm_mem_writer.sv
// Self-checking bench for pdm_mem_writer (DEPTH=8, FIFO_DEPTH=4): scoreboard on memory writes,
// table-driven capture runs, and hand sequences for overflow, clear, drain, reset and density.
module tb_pdm_mem_writer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;
    localparam int FIFO_DEPTH = 4;
`ifdef PDM_DENSITY_EN
    localparam logic [31:0] EXP_DENS = 32'd36;
`else
    localparam logic [31:0] EXP_DENS = 32'd0;
`endif

    logic              ahb_clk, rst, in_valid, mem_we, mem_ack, bsy, done, ovf;
    logic [1:0]        ctrl;
    logic [DATA_W-1:0] in_data, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W:0]   wr_count;
    logic [31:0]       density;

    pdm_mem_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .ahb_clk(ahb_clk), .rst(rst), .ctrl(ctrl), .in_valid(in_valid), .in_data(in_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .bsy(bsy), .done(done), .ovf(ovf), .wr_count(wr_count), .density(density)
    );

    initial ahb_clk = 1'b0;
    always #5 ahb_clk = ~ahb_clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        int          n;
        int          gap;
        int          stop;
        logic [31:0] base;
        int          exp_wc;
        logic        exp_ovf;
    } vec_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  nxt_addr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ahb_clk);
        #1;
    endtask

    task automatic strobe(input logic [DATA_W-1:0] d, input bit exp_acc);
        wr_t w;
        in_valid = 1'b1;
        in_data  = d;
        if (exp_acc) begin
            w.addr = ADDR_W'(nxt_addr);
            w.data = d;
            exp_q.push_back(w);
            nxt_addr++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_capture();
        ctrl     = 2'b01;
        nxt_addr = 0;
        tick();
    endtask

    task automatic wait_done(input string name, input int exp_wc, input logic exp_ovf);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge ahb_clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_wr_count"}, 64'(wr_count), 64'(exp_wc));
        check({name, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge ahb_clk);
        check({name, "_mem_we"}, 64'(mem_we), 64'd0);
        check({name, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({name, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({name, "_bsy"}, 64'(bsy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_ovf"}, 64'(ovf), 64'd0);
        check({name, "_wr_count"}, 64'(wr_count), 64'd0);
        check({name, "_density"}, 64'(density), 64'd0);
    endtask

    // Write monitor: pops the scoreboard on each accepted write and checks that a
    // stalled request stays stable until it is acknowledged.
    logic              hold_v = 1'b0, rst_p = 1'b0, clr_p = 1'b0;
    logic [ADDR_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_d;
    always @(negedge ahb_clk) begin
        wr_t e;
        if (hold_v && !rst_p && !clr_p) begin
            check("hold_we", 64'(mem_we), 64'd1);
            check("hold_addr", 64'(mem_addr), 64'(hold_a));
            check("hold_data", 64'(mem_wdata), 64'(hold_d));
        end
        if (mem_we && mem_ack && !rst) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
        hold_v = mem_we && !mem_ack && !rst;
        hold_a = mem_addr;
        hold_d = mem_wdata;
        rst_p  = rst;
        clr_p  = ctrl[1];
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    vec_t vecs[4];

    initial begin
        int acc;
        vecs[0] = '{n: 8,  gap: 2, stop: 0, base: 32'h0000_0001, exp_wc: 8, exp_ovf: 1'b0};
        vecs[1] = '{n: 8,  gap: 0, stop: 0, base: 32'hA000_0000, exp_wc: 8, exp_ovf: 1'b0};
        vecs[2] = '{n: 10, gap: 0, stop: 0, base: 32'h5500_0000, exp_wc: 8, exp_ovf: 1'b0};
        vecs[3] = '{n: 8,  gap: 1, stop: 5, base: 32'hC000_0010, exp_wc: 5, exp_ovf: 1'b0};

        rst = 1'b1; ctrl = 2'b00; in_valid = 1'b0; in_data = '0; mem_ack = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // Table-driven capture runs with mem_ack tied high.
        for (int v = 0; v < 4; v++) begin
            mem_ack = 1'b1;
            start_capture();
            acc = 0;
            for (int i = 0; i < vecs[v].n; i++) begin
                if (vecs[v].stop != 0 && i == vecs[v].stop) break;
                strobe(vecs[v].base + 32'(i), acc < DEPTH);
                acc++;
                repeat (vecs[v].gap) tick();
            end
            if (vecs[v].stop != 0) ctrl = 2'b00;
            wait_done($sformatf("vec%0d", v), vecs[v].exp_wc, vecs[v].exp_ovf);
            if (vecs[v].stop == 0) begin
                repeat (3) tick();
                @(negedge ahb_clk);
                check($sformatf("vec%0d_done_held", v), 64'(done), 64'd1);
            end
            tick();
            ctrl = 2'b00;
            repeat (2) tick();
        end

        // Overflow: memory stalled, six back-to-back words into a four-entry FIFO.
        start_capture();
        mem_ack = 1'b0;
        for (int i = 0; i < 6; i++) strobe(32'h0000_00B0 + 32'(i), i < FIFO_DEPTH);
        @(negedge ahb_clk);
        check("ovf_set", 64'(ovf), 64'd1);
        check("ovf_we_stalled", 64'(mem_we), 64'd1);
        check("ovf_head_addr", 64'(mem_addr), 64'd0);
        check("ovf_head_data", 64'(mem_wdata), 64'h0B0);
        tick();
        mem_ack = 1'b1;
        repeat (4) tick();
        @(negedge ahb_clk);
        check("ovf_drained_we", 64'(mem_we), 64'd0);
        check("ovf_wr_count", 64'(wr_count), 64'd4);
        check("ovf_still_run_bsy", 64'(bsy), 64'd1);
        check("ovf_still_run_done", 64'(done), 64'd0);
        check("ovf_sb_empty", 64'(exp_q.size()), 64'd0);
        tick();
        ctrl = 2'b00;
        repeat (4) tick();
        @(negedge ahb_clk);
        check("ovf_idle_bsy", 64'(bsy), 64'd0);
        check("ovf_hold_wr_count", 64'(wr_count), 64'd4);
        check("ovf_hold_sticky", 64'(ovf), 64'd1);

        // Clear mid-capture with one write still pending; start must clear ovf first.
        tick();
        start_capture();
        @(negedge ahb_clk);
        check("start_clears_ovf", 64'(ovf), 64'd0);
        check("start_clears_wr_count", 64'(wr_count), 64'd0);
        tick();
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe(32'h0000_00C0 + 32'(i), 1'b1);
            repeat (2) tick();
        end
        mem_ack = 1'b0;
        strobe(32'h0000_00C3, 1'b1);
        ctrl = 2'b11;
        tick();
        @(negedge ahb_clk);
        check("clr_bsy", 64'(bsy), 64'd0);
        check("clr_done", 64'(done), 64'd0);
        check("clr_mem_we", 64'(mem_we), 64'd0);
        check("clr_wr_count", 64'(wr_count), 64'd0);
        check("clr_ovf", 64'(ovf), 64'd0);
        exp_q.delete();
        tick();
        ctrl = 2'b00;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) strobe(32'h0000_00CF, 1'b0);
        @(negedge ahb_clk);
        check("idle_ignores_we", 64'(mem_we), 64'd0);
        check("idle_ignores_wr_count", 64'(wr_count), 64'd0);
        tick();

        // Drop start after five words with two still buffered; DRAIN must flush them.
        start_capture();
        for (int i = 0; i < 3; i++) begin
            strobe(32'h0000_00D0 + 32'(i), 1'b1);
            repeat (2) tick();
        end
        mem_ack = 1'b0;
        strobe(32'h0000_00D3, 1'b1);
        strobe(32'h0000_00D4, 1'b1);
        ctrl = 2'b00;
        tick();
        @(negedge ahb_clk);
        check("drain_bsy", 64'(bsy), 64'd1);
        check("drain_we", 64'(mem_we), 64'd1);
        check("drain_addr", 64'(mem_addr), 64'd3);
        tick();
        mem_ack = 1'b1;
        wait_done("drain", 5, 1'b0);
        tick();

        // Reset while a write is stalled.
        start_capture();
        mem_ack = 1'b0;
        strobe(32'h0000_00E0, 1'b1);
        @(negedge ahb_clk);
        check("rst_pre_we", 64'(mem_we), 64'd1);
        tick();
        rst = 1'b1;
        ctrl = 2'b00;
        tick();
        check_reset_outputs("rst_mid");
        exp_q.delete();
        tick();
        rst = 1'b0;
        mem_ack = 1'b1;
        tick();

        // Density accumulation over three accepted words.
        start_capture();
        strobe(32'hFFFF_FFFF, 1'b1);
        strobe(32'h0000_000F, 1'b1);
        strobe(32'h0000_0000, 1'b1);
        @(negedge ahb_clk);
        check("density", 64'(density), 64'(EXP_DENS));
        tick();
        ctrl = 2'b00;
        repeat (6) tick();
        @(negedge ahb_clk);
        check("density_wr_count", 64'(wr_count), 64'd3);
        check("density_sb_empty", 64'(exp_q.size()), 64'd0);
        tick();
        start_capture();
        @(negedge ahb_clk);
        check("density_cleared_on_start", 64'(density), 64'd0);
        tick();
        ctrl = 2'b00;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pdm_mem_writer.md
Name: pdm_mem_writer

Overview:
Downstream stage of the PDM shift/capture controller. Takes completed 32-bit PDM words, buffers them in a small FIFO, and writes them sequentially into capture memory (BRAM port) from address 0 up to DEPTH-1. Reports busy, done, overflow and word count to the AHB-side control logic. Single clock domain (ahb_clk); upstream word strobes arrive already synchronised to ahb_clk.

Parameters:
DATA_W, 32, PDM word width
ADDR_W, 16, memory address width
DEPTH, 49152, words per capture; 1 <= DEPTH <= 2^ADDR_W
FIFO_DEPTH, 4, elastic buffer entries; power of 2, >= 2

Ports:
ahb_clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
ctrl  in  2  bit0 = start/enable (level), bit1 = clear (level, highest priority)
in_valid  in  1  one-cycle strobe: in_data holds a new PDM word
in_data  in  DATA_W  PDM word from shift stage
mem_we  out  1  write request to capture memory
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
mem_ack  in  1  memory accepted the current write this cycle
bsy  out  1  high in RUN and DRAIN
done  out  1  high in DONE
ovf  out  1  sticky: a word was dropped because the FIFO was full
wr_count  out  ADDR_W+1  words written to memory in the current capture
density  out  32  running popcount of accepted words (see Optional Feature)

Behaviour:
- Reset (rst=1 at clock edge): state IDLE, FIFO empty, mem_we=0, mem_addr=0, mem_wdata=0, bsy=0, done=0, ovf=0, wr_count=0, density=0, accept counter=0. Reset mid-capture aborts the capture immediately. No partial write is retried.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_valid ignored. If ctrl[0]=1 and ctrl[1]=0, go to RUN next cycle. On entry to RUN: addr=0, wr_count=0, accept counter=0, ovf=0, density=0, FIFO flushed.
- RUN: each in_valid pushes in_data if the FIFO has space. A slot counts as free when FIFO is not full, or when a pop occurs in the same cycle. If in_valid arrives with no space, the word is dropped, ovf is set (sticky), and the accept counter is not incremented. When the accept counter reaches DEPTH, further in_valid are ignored and the state goes to DRAIN. If ctrl[0] falls in RUN, go to DRAIN.
- Write side (RUN and DRAIN): mem_we=1 whenever the FIFO is non-empty, with mem_wdata = FIFO head and mem_addr = current addr. mem_we, mem_addr and mem_wdata hold stable until mem_ack. On mem_we and mem_ack: pop, addr+1, wr_count+1. mem_ack with mem_we=0 is ignored.
- DRAIN: no pushes. When the FIFO is empty and no write is pending, go to DONE.
- DONE: done=1, mem_we=0. Stays in DONE while ctrl[0]=1. Goes to IDLE when ctrl[0]=0. wr_count and ovf hold until the next start or clear.
- ctrl[1]=1 in any state: go to IDLE next cycle, flush FIFO, mem_we=0, clear ovf, wr_count, addr and density. Clear overrides start in the same cycle.
- Addresses never exceed DEPTH-1. The write count is capped at DEPTH by the accept counter, so addr never wraps.
- Latency: an in_valid accepted into an empty FIFO produces mem_we=1 on the next cycle. With mem_ack tied to 1, throughput is one word per cycle.

Optional Feature:
PDM_DENSITY_EN
- Defined: each accepted word adds its popcount (0..32) to density, wrapping modulo 2^32. The update is registered and lands one cycle after acceptance. Dropped words are not counted. density clears on start, clear and reset.
- Undefined: density is constant 0 and no popcount logic is built.

Test Plan:
- DEPTH=8, mem_ack=1, ctrl=01, 8 in_valid strobes spaced 3 cycles with data 0x1..0x8 -> writes to addr 0..7 with matching data; wr_count=8; done=1; ovf=0.
- DEPTH=8, FIFO_DEPTH=4, mem_ack held 0, 6 back-to-back strobes -> first 4 buffered, ovf=1. After mem_ack=1: 4 writes at addr 0..3, and state is still RUN.
- Capture running, ctrl=11 after 3 words -> IDLE next cycle, mem_we=0, wr_count=0, ovf=0; in_valid then ignored.
- ctrl[0] dropped after 5 of 8 words with 2 words still in the FIFO -> DRAIN writes the 2 remaining words, then DONE with wr_count=5.
- rst=1 mid-write with mem_we=1 and mem_ack=0 -> next cycle all outputs at reset values and state IDLE.
- PDM_DENSITY_EN defined, words 0xFFFFFFFF, 0x0000000F, 0x00000000 -> density=36 one cycle after the third acceptance. With the macro undefined -> density=0.
